// File: rtl/dsp_instr_sequencer_if.sv
// Host/core-facing bus of the DSP instruction sequencer.
// Signal prefixes are from the sequencer's point of view.
interface dsp_instr_sequencer_if #(
  parameter int INSTR_WIDTH     = 26,
  parameter int PROG_ADDR_WIDTH = 10
);
  logic                       i_sample_tick;
  logic                       i_prog_wr_en;
  logic [PROG_ADDR_WIDTH-1:0] i_prog_wr_addr;
  logic [INSTR_WIDTH-1:0]     i_prog_wr_data;
  logic                       i_len_wr_en;
  logic [PROG_ADDR_WIDTH:0]   i_len_wr_data;
  logic                       i_swap_req;
  logic                       i_overrun_clr;
  logic [INSTR_WIDTH-1:0]     o_instruction;
  logic [PROG_ADDR_WIDTH-1:0] o_pc;
  logic                       o_active_bank;
  logic                       o_swap_pending;
  logic                       o_busy;
  logic                       o_frame_done;
  logic                       o_overrun;

  modport master (
    output i_sample_tick, i_prog_wr_en, i_prog_wr_addr, i_prog_wr_data,
           i_len_wr_en, i_len_wr_data, i_swap_req, i_overrun_clr,
    input  o_instruction, o_pc, o_active_bank, o_swap_pending, o_busy,
           o_frame_done, o_overrun
  );

  modport slave (
    input  i_sample_tick, i_prog_wr_en, i_prog_wr_addr, i_prog_wr_data,
           i_len_wr_en, i_len_wr_data, i_swap_req, i_overrun_clr,
    output o_instruction, o_pc, o_active_bank, o_swap_pending, o_busy,
           o_frame_done, o_overrun
  );
endinterface

// File: rtl/dsp_instr_sequencer.sv
// Double-banked program sequencer feeding dsp_core one instruction per clock;
// runs the active bank on each sample tick, drains the core pipeline, then flags frame_done.
module dsp_instr_sequencer #(
  parameter int INSTR_WIDTH     = 26,
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int PIPE_DEPTH      = 4
) (
  input logic                  i_clk,
  input logic                  i_reset,
  dsp_instr_sequencer_if.slave bus
);
  localparam int AW    = PROG_ADDR_WIDTH;
  localparam int DEPTH = 2 ** AW;
  localparam int CW    = $clog2(PIPE_DEPTH + 1) + 1;
  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 r_state;
  logic [AW-1:0]          r_pc;
  logic [CW-1:0]          r_drain_cnt;
  logic                   r_active_bank;
  logic                   r_swap_pending;
  logic [AW:0]            r_len_act;
  logic [AW:0]            r_len_shd;
  logic                   r_overrun;
  logic                   r_frame_done;
  logic                   r_busy;
  logic                   r_valid;
  logic [INSTR_WIDTH-1:0] r_mem_q;
  logic [INSTR_WIDTH-1:0] r_mem [0:2*DEPTH-1];

  logic [AW:0] w_next_len;
  logic        w_last;

  assign w_next_len = r_swap_pending ? r_len_shd : r_len_act;
  assign w_last     = (({1'b0, r_pc} + {{AW{1'b0}}, 1'b1}) == r_len_act);

  // Writes always target the bank that is not executing before this edge.
  always_ff @(posedge i_clk) begin
    if (bus.i_prog_wr_en) begin
      r_mem[{~r_active_bank, bus.i_prog_wr_addr}] <= bus.i_prog_wr_data;
    end
    if (r_state == S_RUN) begin
      r_mem_q <= r_mem[{r_active_bank, r_pc}];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_pc           <= {AW{1'b0}};
      r_drain_cnt    <= {CW{1'b0}};
      r_active_bank  <= 1'b0;
      r_swap_pending <= 1'b0;
      r_len_act      <= {(AW+1){1'b0}};
      r_len_shd      <= {(AW+1){1'b0}};
      r_overrun      <= 1'b0;
      r_frame_done   <= 1'b0;
      r_busy         <= 1'b0;
      r_valid        <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_valid      <= (r_state == S_RUN);
      if (bus.i_len_wr_en) begin
        r_len_shd <= (bus.i_len_wr_data > LEN_MAX) ? LEN_MAX : bus.i_len_wr_data;
      end
      // Clear first so that a coincident overrun tick wins.
      if (bus.i_overrun_clr) begin
        r_overrun <= 1'b0;
      end
      if (bus.i_sample_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_pc <= {AW{1'b0}};
          if (bus.i_sample_tick) begin
            if (r_swap_pending) begin
              r_active_bank  <= ~r_active_bank;
              r_len_act      <= r_len_shd;
              r_swap_pending <= 1'b0;
            end
            if (w_next_len == {(AW+1){1'b0}}) begin
              r_frame_done <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= {CW{1'b0}};
          end else begin
            r_pc <= r_pc + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == CW'(PIPE_DEPTH)) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b1;
            r_busy       <= 1'b0;
            r_pc         <= {AW{1'b0}};
          end else begin
            r_drain_cnt <= r_drain_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      // A request coincident with the applying tick stays pending for the next one.
      if (bus.i_swap_req) begin
        r_swap_pending <= 1'b1;
      end
    end
  end

  assign bus.o_instruction  = r_valid ? r_mem_q : {INSTR_WIDTH{1'b0}};
  assign bus.o_pc           = r_pc;
  assign bus.o_active_bank  = r_active_bank;
  assign bus.o_swap_pending = r_swap_pending;
  assign bus.o_busy         = r_busy;
  assign bus.o_frame_done   = r_frame_done;
  assign bus.o_overrun      = r_overrun;
endmodule

// File: tb/tb_dsp_instr_sequencer.sv
// Directed bench for dsp_instr_sequencer: a cycle table for the basic frame,
// plus hand-written sequences for overrun, bank isolation, swap timing, saturation and reset.
module tb_dsp_instr_sequencer;
  localparam int IW = 26;
  localparam int AW = 10;
  localparam int PD = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dsp_instr_sequencer_if #(.INSTR_WIDTH(IW), .PROG_ADDR_WIDTH(AW)) bus ();

  dsp_instr_sequencer #(.INSTR_WIDTH(IW), .PROG_ADDR_WIDTH(AW), .PIPE_DEPTH(PD)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          tick;
    logic [IW-1:0] instr;
    logic          busy;
    logic          fd;
    logic          bank;
    logic          pend;
    logic          pc_chk;
    logic [AW-1:0] pc;
  } vec_t;

  vec_t          tbl [0:10];
  logic [IW-1:0] exp_words [0:1023];
  logic [IW-1:0] wr_words  [0:3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [IW-1:0] data);
    bus.i_prog_wr_en   = 1'b1;
    bus.i_prog_wr_addr = AW'(addr);
    bus.i_prog_wr_data = data;
    cyc();
    bus.i_prog_wr_en = 1'b0;
  endtask

  task automatic set_len(input logic [AW:0] len);
    bus.i_len_wr_en   = 1'b1;
    bus.i_len_wr_data = len;
    cyc();
    bus.i_len_wr_en = 1'b0;
  endtask

  task automatic swap();
    bus.i_swap_req = 1'b1;
    cyc();
    bus.i_swap_req = 1'b0;
  endtask

  // Cycle c=0 is the tick cycle; expectations come from the frame timing model.
  task automatic run_frame(input int len, input int tick2, input bit do_wr,
                           input bit swap_at_tick, input bit exp_bank, input string tag);
    int            fd_c;
    logic [IW-1:0] exp_i;
    fd_c = (len == 0) ? 1 : len + PD + 2;
    for (int c = 0; c <= len + PD + 3; c++) begin
      bus.i_sample_tick = (c == 0) || (c == tick2);
      bus.i_swap_req    = swap_at_tick && (c == 0);
      if (do_wr && c >= 1 && c <= 4) begin
        bus.i_prog_wr_en   = 1'b1;
        bus.i_prog_wr_addr = AW'(c - 1);
        bus.i_prog_wr_data = wr_words[c-1];
      end else begin
        bus.i_prog_wr_en = 1'b0;
      end
      #3;
      exp_i = (c >= 2 && c < len + 2) ? exp_words[c-2] : '0;
      chk({tag, "_instr"}, 32'(bus.o_instruction), 32'(exp_i));
      chk({tag, "_busy"}, 32'(bus.o_busy), 32'((len != 0) && c >= 1 && c <= len + PD + 1));
      chk({tag, "_frame_done"}, 32'(bus.o_frame_done), 32'(c == fd_c));
      if (c >= 1 && c <= len) chk({tag, "_pc"}, 32'(bus.o_pc), 32'(c - 1));
      if (c >= 1) chk({tag, "_bank"}, 32'(bus.o_active_bank), 32'(exp_bank));
      cyc();
      bus.i_sample_tick = 1'b0;
      bus.i_swap_req    = 1'b0;
      bus.i_prog_wr_en  = 1'b0;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.i_sample_tick  = 1'b0;
    bus.i_prog_wr_en   = 1'b0;
    bus.i_prog_wr_addr = '0;
    bus.i_prog_wr_data = '0;
    bus.i_len_wr_en    = 1'b0;
    bus.i_len_wr_data  = '0;
    bus.i_swap_req     = 1'b0;
    bus.i_overrun_clr  = 1'b0;

    //                tick  instr        busy  fd    bank  pend  pcchk pc
    tbl[0]  = '{1'b1, 26'h0000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0};
    tbl[1]  = '{1'b0, 26'h0000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'd0};
    tbl[2]  = '{1'b0, 26'h0400001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'd1};
    tbl[3]  = '{1'b0, 26'h0800002, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'd2};
    tbl[4]  = '{1'b0, 26'h1000003, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0};
    tbl[5]  = '{1'b0, 26'h0000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0};
    tbl[6]  = '{1'b0, 26'h0000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0};
    tbl[7]  = '{1'b0, 26'h0000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0};
    tbl[8]  = '{1'b0, 26'h0000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0};
    tbl[9]  = '{1'b0, 26'h0000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd0};
    tbl[10] = '{1'b0, 26'h0000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd0};

    repeat (3) @(posedge clk);
    #4;
    chk("rst_instr", 32'(bus.o_instruction), 32'd0);
    chk("rst_pc", 32'(bus.o_pc), 32'd0);
    chk("rst_bank", 32'(bus.o_active_bank), 32'd0);
    chk("rst_pending", 32'(bus.o_swap_pending), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_frame_done", 32'(bus.o_frame_done), 32'd0);
    chk("rst_overrun", 32'(bus.o_overrun), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // Basic frame from bank 1, driven from the cycle table.
    write_word(0, 26'h0400001);
    write_word(1, 26'h0800002);
    write_word(2, 26'h1000003);
    set_len(11'd3);
    swap();
    for (int i = 0; i <= 10; i++) begin
      bus.i_sample_tick = tbl[i].tick;
      #3;
      chk($sformatf("t1_instr[%0d]", i), 32'(bus.o_instruction), 32'(tbl[i].instr));
      chk($sformatf("t1_busy[%0d]", i), 32'(bus.o_busy), 32'(tbl[i].busy));
      chk($sformatf("t1_fd[%0d]", i), 32'(bus.o_frame_done), 32'(tbl[i].fd));
      chk($sformatf("t1_bank[%0d]", i), 32'(bus.o_active_bank), 32'(tbl[i].bank));
      chk($sformatf("t1_pend[%0d]", i), 32'(bus.o_swap_pending), 32'(tbl[i].pend));
      if (tbl[i].pc_chk) chk($sformatf("t1_pc[%0d]", i), 32'(bus.o_pc), 32'(tbl[i].pc));
      cyc();
      bus.i_sample_tick = 1'b0;
    end

    // Overrun: second tick three cycles into an 8-word frame of bank 0.
    for (int i = 0; i < 8; i++) begin
      exp_words[i] = 26'h0000100 + IW'(i);
      write_word(i, exp_words[i]);
    end
    set_len(11'd8);
    swap();
    run_frame(8, 3, 1'b0, 1'b0, 1'b0, "t2");
    #3;
    chk("t2_overrun_set", 32'(bus.o_overrun), 32'd1);
    cyc();
    bus.i_overrun_clr = 1'b1;
    cyc();
    bus.i_overrun_clr = 1'b0;
    #3;
    chk("t2_overrun_clr", 32'(bus.o_overrun), 32'd0);
    cyc();

    // Bank 1 executes while bank 0 is rewritten; then bank 0 runs the new words.
    for (int i = 0; i < 4; i++) begin
      exp_words[i] = 26'h2000000 + IW'(i * 16 + 5);
      wr_words[i]  = 26'h3000000 + IW'(i * 7 + 9);
      write_word(i, exp_words[i]);
    end
    set_len(11'd4);
    swap();
    run_frame(4, -1, 1'b1, 1'b0, 1'b1, "t3a");
    for (int i = 0; i < 4; i++) exp_words[i] = wr_words[i];
    swap();
    run_frame(4, -1, 1'b0, 1'b0, 1'b0, "t3b");

    // swap_req coincident with tick: old bank runs, swap applies at the next tick.
    write_word(0, 26'h0AAAAAA);
    write_word(1, 26'h1555555);
    set_len(11'd2);
    run_frame(4, -1, 1'b0, 1'b1, 1'b0, "t5a");
    #3;
    chk("t5_pending_kept", 32'(bus.o_swap_pending), 32'd1);
    cyc();
    exp_words[0] = 26'h0AAAAAA;
    exp_words[1] = 26'h1555555;
    run_frame(2, -1, 1'b0, 1'b0, 1'b1, "t5b");
    #3;
    chk("t5_pending_clr", 32'(bus.o_swap_pending), 32'd0);
    cyc();

    // Zero length: no instruction, frame_done one cycle after the tick.
    set_len(11'd0);
    swap();
    run_frame(0, -1, 1'b0, 1'b0, 1'b0, "t4");

    // Oversized length saturates to a full bank ending at pc all-ones.
    for (int i = 0; i < 1024; i++) begin
      exp_words[i] = IW'(i * 3 + 1);
      write_word(i, exp_words[i]);
    end
    set_len(11'h7FF);
    swap();
    run_frame(1024, -1, 1'b0, 1'b0, 1'b1, "sat");

    // Reset mid-frame clears instruction at once and suppresses frame_done.
    bus.i_sample_tick = 1'b1;
    cyc();
    bus.i_sample_tick = 1'b0;
    repeat (4) cyc();
    chk("t6_pre_instr", 32'(bus.o_instruction), 32'(exp_words[3]));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_instr", 32'(bus.o_instruction), 32'd0);
    chk("t6_async_busy", 32'(bus.o_busy), 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #3;
      chk($sformatf("t6_no_fd[%0d]", i), 32'(bus.o_frame_done), 32'd0);
      chk($sformatf("t6_idle_instr[%0d]", i), 32'(bus.o_instruction), 32'd0);
      cyc();
    end
    run_frame(0, -1, 1'b0, 1'b0, 1'b0, "t6z");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
